dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-port, synchronous, write-first data memory RAM (1-cycle read latency). Port A is the CPU load/store path and port B the DMA/debug path. The block accepts at most one access per cycle, drives the RAM's enable, write-enable, address and write-data pins from registers, and routes each result back to the requester that issued it. It is fully pipelined: one access per cycle sustained, 2-cycle request-to-response latency.

## Interface
- ADDRESS_WIDTH, 8: RAM word-address width.
- DATA_WIDTH, 32: data word width.
- STARVE_LIMIT, 4: consecutive contested A-wins before B is forced through. Used only with the guard macro; legal range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_req / b_req  in  1  request; held high with fields stable until the matching gnt.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  ADDRESS_WIDTH  word address.
- a_wdata / b_wdata  in  DATA_WIDTH  write data.
- a_gnt / b_gnt  out  1  combinational; request accepted at this edge.
- a_rvalid / b_rvalid  out  1  registered; one-cycle response pulse.
- a_rdata / b_rdata  out  DATA_WIDTH  mem_rd when own rvalid is 1, else 0.
- mem_en  out  1  registered RAM enable.
- mem_we  out  1  registered RAM write enable.
- mem_addr  out  ADDRESS_WIDTH  registered RAM address.
- mem_wdata  out  DATA_WIDTH  registered RAM write data.
- mem_rd  in  DATA_WIDTH  RAM read-data output.

## Operation
- Arbitration is evaluated every cycle:
  - Only one req high: that port is granted.
  - Both high: A is granted (fixed priority), subject to the starvation guard.
  - Neither high: no grant.
  - a_gnt and b_gnt are never high together.
  - gnt never asserts without the matching req.
- Stage 1 (issue), on a grant edge:
  - mem_en <= 1.
  - mem_we, mem_addr, mem_wdata <= the winner's fields.
  - iss_port <= winner (0 = A, 1 = B).
  - With no grant, mem_en <= 0; mem_we <= 0; addr/wdata hold their values.
- Stage 2 (response):
  - rsp_valid <= mem_en; rsp_port <= iss_port.
  - x_rvalid = rsp_valid and (rsp_port == x).
- Every accepted access, read or write, produces exactly one rvalid on its own port, in acceptance order.
  - Write responses return the written data, because the RAM is write-first.
- There is no response backpressure. Requesters must take the rvalid pulse when it occurs.
- Back-to-back accesses to the same address need no hazard logic. The RAM orders them in acceptance order, so a read issued the cycle after a write returns the new data.
- Reset (rst_n low, at any time):
  - All gnt and rvalid outputs are 0; mem_en and mem_we are 0.
  - mem_addr, mem_wdata and both rdata outputs are 0.
  - The pipeline is flushed; the starvation counter is 0.
  - In-flight accesses are dropped and produce no rvalid after reset is released.
  - A write already sampled by the RAM stays written.

## Timing
- Cycle N: req high and gnt high (combinational), accepted at the end-of-N edge.
- Cycle N+1: mem_en, mem_we, mem_addr and mem_wdata are valid. The RAM samples at the end-of-N+1 edge.
- Cycle N+2: x_rvalid = 1 and x_rdata = mem_rd.
- Throughput is one access per cycle. Grants at N, N+1, N+2 give rvalids at N+2, N+3, N+4.
- The first grant is possible in the cycle rst_n is released, if a req is already high.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each edge where A is granted while b_req is high.
  - It clears when B is granted, or when b_req is low.
  - When the counter equals STARVE_LIMIT and both reqs are high, B is granted instead of A and the counter clears.
- DMEM_ARB_STARVE_GUARD_EN undefined:
  - Pure fixed priority to A; B can starve indefinitely.
  - No counter is built.

## Test plan
- Reset: hold rst_n=0 with both reqs high -> all outputs 0, no gnt. Release -> a_gnt in the same cycle; a_rvalid 2 cycles later.
- A writes 0xDEADBEEF to addr 0x10 at cycle N, then reads 0x10 at N+1 -> a_rvalid at N+2 with 0xDEADBEEF (write echo) and at N+3 with 0xDEADBEEF (read).
- Both ports request continuously (A reads 0x01, B reads 0x02), guard macro off -> a_gnt every cycle, b_gnt never, b_rvalid never.
- Same stimulus, guard on, STARVE_LIMIT=4 -> grant pattern A,A,A,A,B repeating; B's data returned 2 cycles after each b_gnt on b_rdata only; a_rdata is 0 in that cycle.
- Interleaved single requests (B write 0x5A5A5A5A to 0x20, then A read 0x20 next cycle) -> a_rdata = 0x5A5A5A5A.
- Assert rst_n low for 1 cycle between a grant and its response -> no rvalid from the flushed access; mem_en=0 during reset.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: bundle of requester ports A/B and the RAM pins for dmem_arbiter.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata stable and
// holds them until x_gnt is high. x_gnt is combinational and means "taken at
// this rising edge". The result returns as a single-cycle x_rvalid pulse two
// cycles later, with no backpressure.
interface dmem_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    logic                     a_req;
    logic                     a_we;
    logic [ADDRESS_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0]    a_wdata;
    logic                     a_gnt;
    logic                     a_rvalid;
    logic [DATA_WIDTH-1:0]    a_rdata;

    logic                     b_req;
    logic                     b_we;
    logic [ADDRESS_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0]    b_wdata;
    logic                     b_gnt;
    logic                     b_rvalid;
    logic [DATA_WIDTH-1:0]    b_rdata;

    logic                     mem_en;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_rd;

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rd
    );

    // Requester and RAM side.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port fixed-priority arbiter and 2-stage sequencer in front
// of a single-port write-first RAM with 1-cycle read latency.
// Optional feature macro: DMEM_ARB_STARVE_GUARD_EN (anti-starvation for B).
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);
    logic                     sel_a;
    logic                     sel_b;

    logic                     mem_en_q;
    logic                     mem_we_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]    mem_wdata_q;
    logic                     iss_port;   // 0 = A, 1 = B
    logic                     a_rv_q;
    logic                     b_rv_q;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;
    logic       force_b;

    assign force_b = bus.a_req && bus.b_req && (starve_cnt == LIMIT);
`endif

    // Pick the winner; grants are held off while reset is asserted.
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (rst_n) begin
`ifdef DMEM_ARB_STARVE_GUARD_EN
            if (force_b) begin
                sel_b = 1'b1;
            end else if (bus.a_req) begin
                sel_a = 1'b1;
            end else if (bus.b_req) begin
                sel_b = 1'b1;
            end
`else
            if (bus.a_req) begin
                sel_a = 1'b1;
            end else if (bus.b_req) begin
                sel_b = 1'b1;
            end
`endif
        end
    end

    // Issue stage: register the winner's access onto the RAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            iss_port    <= 1'b0;
        end else if (sel_a || sel_b) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_b ? bus.b_we    : bus.a_we;
            mem_addr_q  <= sel_b ? bus.b_addr  : bus.a_addr;
            mem_wdata_q <= sel_b ? bus.b_wdata : bus.a_wdata;
            iss_port    <= sel_b;
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end
    end

    // Response stage: steer the RAM result back to the issuing port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rv_q <= 1'b0;
            b_rv_q <= 1'b0;
        end else begin
            a_rv_q <= mem_en_q && !iss_port;
            b_rv_q <= mem_en_q &&  iss_port;
        end
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    // Count contested A-wins; any B grant or idle B restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (sel_b || !bus.b_req) begin
            starve_cnt <= 4'd0;
        end else if (sel_a) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    assign bus.a_gnt     = sel_a;
    assign bus.b_gnt     = sel_b;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.a_rvalid  = a_rv_q;
    assign bus.b_rvalid  = b_rv_q;
    assign bus.a_rdata   = a_rv_q ? bus.mem_rd : '0;
    assign bus.b_rdata   = b_rv_q ? bus.mem_rd : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + random stimulus for dmem_arbiter against a
// reference model of arbitration rules, acceptance-ordered memory contents
// and 2-cycle response timing. Honors DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_arbiter;
    localparam int AW           = 8;
    localparam int DW           = 32;
    localparam int STARVE_LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dmem_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- RAM (write-first, 1-cycle read) ----------------
    logic [DW-1:0] ram [256] = '{default: '0};
    logic [DW-1:0] ram_rd    = '0;
    assign bus.mem_rd = ram_rd;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
                ram_rd            <= bus.mem_wdata;
            end else begin
                ram_rd <= ram[bus.mem_addr];
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    logic [DW-1:0] a_exp_q[$];
    logic [DW-1:0] b_exp_q[$];
    int            a_due_q[$];
    int            b_due_q[$];
    int            cyc        = 0;
    int            starve     = 0;
    logic          prev_acc   = 1'b0;
    logic          prev_we    = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [DW-1:0] prev_wdata = '0;
    logic          last_ga    = 1'b0;
    logic          last_gb    = 1'b0;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic accept(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        logic [DW-1:0] d;
        if (we) begin
            ref_mem[addr] = wdata;
            d = wdata;
        end else begin
            d = ref_mem[addr];
        end
        if (port) begin
            b_exp_q.push_back(d);
            b_due_q.push_back(cyc + 2);
        end else begin
            a_exp_q.push_back(d);
            a_due_q.push_back(cyc + 2);
        end
        prev_we    = we;
        prev_addr  = addr;
        prev_wdata = wdata;
    endtask

    // One clock cycle: check at the falling edge, advance model, then
    // return 1 time unit after the rising edge for the caller to drive.
    task automatic step();
        logic          fb, eg_a, eg_b, ev;
        logic [DW-1:0] ed;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_a_gnt",     bus.a_gnt,     '0);
            chk("rst_b_gnt",     bus.b_gnt,     '0);
            chk("rst_a_rvalid",  bus.a_rvalid,  '0);
            chk("rst_b_rvalid",  bus.b_rvalid,  '0);
            chk("rst_a_rdata",   bus.a_rdata,   '0);
            chk("rst_b_rdata",   bus.b_rdata,   '0);
            chk("rst_mem_en",    bus.mem_en,    '0);
            chk("rst_mem_we",    bus.mem_we,    '0);
            chk("rst_mem_addr",  bus.mem_addr,  '0);
            chk("rst_mem_wdata", bus.mem_wdata, '0);
            a_exp_q.delete(); a_due_q.delete();
            b_exp_q.delete(); b_due_q.delete();
            starve   = 0;
            prev_acc = 1'b0;
            last_ga  = 1'b0;
            last_gb  = 1'b0;
        end else begin
            fb = 1'b0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
            fb = bus.a_req && bus.b_req && (starve == STARVE_LIMIT);
`endif
            eg_a = bus.a_req && !fb;
            eg_b = bus.b_req && (!bus.a_req || fb);
            chk("a_gnt", bus.a_gnt, eg_a);
            chk("b_gnt", bus.b_gnt, eg_b);

            chk("mem_en", bus.mem_en, prev_acc);
            if (prev_acc) begin
                chk("mem_we",    bus.mem_we,    prev_we);
                chk("mem_addr",  bus.mem_addr,  prev_addr);
                chk("mem_wdata", bus.mem_wdata, prev_wdata);
            end else begin
                chk("mem_we_idle", bus.mem_we, '0);
            end

            while (a_due_q.size() > 0 && a_due_q[0] < cyc) begin
                void'(a_due_q.pop_front()); void'(a_exp_q.pop_front());
            end
            ev = (a_due_q.size() > 0) && (a_due_q[0] == cyc);
            ed = ev ? a_exp_q[0] : '0;
            chk("a_rvalid", bus.a_rvalid, ev);
            chk("a_rdata",  bus.a_rdata,  ed);
            if (ev) begin
                void'(a_due_q.pop_front()); void'(a_exp_q.pop_front());
            end

            while (b_due_q.size() > 0 && b_due_q[0] < cyc) begin
                void'(b_due_q.pop_front()); void'(b_exp_q.pop_front());
            end
            ev = (b_due_q.size() > 0) && (b_due_q[0] == cyc);
            ed = ev ? b_exp_q[0] : '0;
            chk("b_rvalid", bus.b_rvalid, ev);
            chk("b_rdata",  bus.b_rdata,  ed);
            if (ev) begin
                void'(b_due_q.pop_front()); void'(b_exp_q.pop_front());
            end

            prev_acc = eg_a || eg_b;
            if (eg_a) accept(1'b0, bus.a_we, bus.a_addr, bus.a_wdata);
            else if (eg_b) accept(1'b1, bus.b_we, bus.b_addr, bus.b_wdata);

            if (eg_b || !bus.b_req) starve = 0;
            else if (eg_a) starve = starve + 1;
            last_ga = eg_a;
            last_gb = eg_b;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // ---------------- driver helpers ----------------
    task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b1;
        drive_a(1'b1, 1'b0, 8'h01, '0);
        drive_b(1'b1, 1'b0, 8'h02, '0);
        #2 rst_n = 1'b0;

        // Reset held with both requests high.
        repeat (3) step();

        // Release: A granted in the same cycle, then both contend.
        rst_n = 1'b1;
        repeat (16) step();
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        repeat (3) step();

        // A writes then reads back the same address.
        drive_a(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        step();
        drive_a(1'b1, 1'b0, 8'h10, '0);
        step();
        drive_a(1'b0, 1'b0, '0, '0);
        repeat (3) step();

        // B writes, A reads the same word on the next cycle.
        drive_b(1'b1, 1'b1, 8'h20, 32'h5A5A5A5A);
        step();
        drive_b(1'b0, 1'b0, '0, '0);
        drive_a(1'b1, 1'b0, 8'h20, '0);
        step();
        drive_a(1'b0, 1'b0, '0, '0);
        repeat (3) step();

        // Reset between a grant and its response drops the access.
        drive_a(1'b1, 1'b0, 8'h10, '0);
        step();
        drive_a(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // Random traffic; each requester holds its request until granted.
        for (int i = 0; i < 400; i++) begin
            if (!bus.a_req || last_ga)
                drive_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 7)), $urandom);
            if (!bus.b_req || last_gb)
                drive_b($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 7)), $urandom);
            step();
        end
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
